// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, latched frame configuration
// and default sizing, common to the transmitter and receiver.
package uart_pkg;

    localparam int unsigned DEF_SIZE_DATA    = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic two_stop;
    } uart_cfg_t;

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// Read-side handshake between the TX FIFO and its consumer.
interface uart_tx_fifo_reader_if #(
    parameter int unsigned SIZE_DATA = uart_pkg::DEF_SIZE_DATA
);

    logic                 fifo_empty;
    logic [SIZE_DATA-1:0] fifo_data;
    logic                 fifo_rd_en;

    // master = the reader issuing pops, slave = the FIFO
    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter marking bit boundaries: o_bit_end pulses in the last
// cycle of each CLKS_PER_BIT period, o_bit_pre_end one cycle earlier.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_bit_end,
    output logic o_bit_pre_end
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= RELOAD;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - TW'(1);
        end
    end

    assign o_bit_end     = i_en & (r_cnt == '0);
    assign o_bit_pre_end = i_en & (r_cnt == TW'(1));

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining the TX FIFO: pops one word per frame and
// serialises start, data (LSB first), optional parity and 1/2 stop bits.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA    = DEF_SIZE_DATA,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    uart_tx_fifo_reader_if.master        fifo,
    input  logic                         i_tx_en,
    input  logic                         i_parity_en,
    input  logic                         i_parity_odd,
    input  logic                         i_two_stop,
    output logic                         o_tx,
    output logic                         o_busy,
    output logic                         o_frame_done
);

    localparam int unsigned BW = $clog2(SIZE_DATA + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(SIZE_DATA - 1);

    uart_state_t          r_state, w_state_nxt;
    logic [SIZE_DATA-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    uart_cfg_t            r_cfg, w_cfg_nxt;
    logic                 r_data_xor, w_data_xor_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;

    logic w_bit_end;
    logic w_bit_pre_end;
    logic w_last_stop;
    logic w_final_stop;
    logic w_pop;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_load        (w_pop),
        .i_en          (r_state != IDLE),
        .o_bit_end     (w_bit_end),
        .o_bit_pre_end (w_bit_pre_end)
    );

    assign w_last_stop  = (r_state == STOP) & (r_stop_idx == r_cfg.two_stop);
    assign w_final_stop = w_last_stop & w_bit_end;
    // Popping in the final stop cycle lets the next start bit follow with no gap
    assign w_pop = ~i_rst & i_tx_en & ~fifo.fifo_empty & ((r_state == IDLE) | w_final_stop);
    assign fifo.fifo_rd_en = w_pop;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_idx_nxt = r_stop_idx;
        w_cfg_nxt      = r_cfg;
        w_data_xor_nxt = r_data_xor;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if (w_pop) begin
            w_state_nxt    = START;
            w_shift_nxt    = fifo.fifo_data;
            w_cfg_nxt      = '{parity_en: i_parity_en, parity_odd: i_parity_odd, two_stop: i_two_stop};
            w_data_xor_nxt = ^fifo.fifo_data;
            w_bit_cnt_nxt  = '0;
            w_stop_idx_nxt = 1'b0;
            w_tx_nxt       = 1'b0;
            w_busy_nxt     = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_tx_nxt   = 1'b1;
                    w_busy_nxt = 1'b0;
                end
                START: begin
                    if (w_bit_end) begin
                        w_state_nxt = DATA;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[SIZE_DATA-1:1]};
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            if (r_cfg.parity_en) begin
                                w_state_nxt = PARITY;
                                w_tx_nxt    = r_data_xor ^ r_cfg.parity_odd;
                            end else begin
                                w_state_nxt = STOP;
                                w_tx_nxt    = 1'b1;
                            end
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                            w_tx_nxt      = r_shift[0];
                            w_shift_nxt   = {1'b0, r_shift[SIZE_DATA-1:1]};
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end
                STOP: begin
                    // Registered done pulse is armed one cycle ahead of the final cycle
                    w_done_nxt = w_last_stop & w_bit_pre_end;
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_stop_idx_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_idx <= 1'b0;
            r_cfg      <= '0;
            r_data_xor <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_cfg      <= w_cfg_nxt;
            r_data_xor <= w_data_xor_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Scoreboard bench: pushes expected frames when words enter the FIFO model;
// a line monitor checks every transmitted frame against a frame-level model.
module tb_uart_tx_fifo_reader;

    localparam int unsigned SD  = 8;
    localparam int unsigned CPB = 4;

    typedef struct {
        logic [7:0] w;
        logic       pe;
        logic       po;
        logic       ts;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    logic pe = 1'b0, po = 1'b0, ts = 1'b0;
    logic o_tx, o_busy, o_frame_done;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;

    logic [7:0]  fifo_q[$];
    exp_t        exp_q[$];
    int unsigned pop_cycles[$];
    int unsigned cyc = 0, last_pop = 0;
    logic        rd_seen = 1'b0;

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned rst_bad = 0, idle_bad = 0, stray = 0, empty_pop = 0, n_abort = 0;

    logic        in_frame = 1'b0, rst_prev = 1'b0;
    exp_t        cur;
    int unsigned cur_len = 0, fc = 0, wave_bad = 0, busy_bad = 0, done_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_reader_if #(.SIZE_DATA(SD)) fif ();
    assign fif.fifo_empty = fifo_empty;
    assign fif.fifo_data  = fifo_data;

    uart_tx_fifo_reader #(
        .SIZE_DATA    (SD),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .fifo         (fif.master),
        .i_tx_en      (tx_en),
        .i_parity_en  (pe),
        .i_parity_odd (po),
        .i_two_stop   (ts),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic int unsigned frame_len(input exp_t e);
        return CPB * (1 + SD + (e.pe ? 1 : 0) + (e.ts ? 2 : 1));
    endfunction

    // Line level of bit slot idx within a frame
    function automatic logic exp_bit(input exp_t e, input int unsigned idx);
        logic ones_odd;
        ones_odd = ($countones(e.w) % 2) == 1;
        if (idx == 0) return 1'b0;
        if (idx <= SD) return e.w[idx-1];
        if (e.pe && idx == SD + 1) return e.po ? ~ones_odd : ones_odd;
        return 1'b1;
    endfunction

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] w);
        exp_t e;
        e.w = w; e.pe = pe; e.po = po; e.ts = ts;
        fifo_q.push_back(w);
        exp_q.push_back(e);
        refresh();
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int unsigned limit, input string tag);
        int unsigned n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || in_frame || o_busy !== 1'b0) && n < limit) begin
            tick(1);
            n++;
        end
        tick(3);
        chk({"drain_", tag}, 32'(n < limit), 1);
    endtask

    task automatic wait_pops(input int unsigned cnt, input int unsigned limit, input string tag);
        int unsigned n = 0;
        while (pop_cycles.size() < cnt && n < limit) begin
            tick(1);
            n++;
        end
        chk({"pop_wait_", tag}, 32'(n < limit), 1);
    endtask

    task automatic check_spacing(input int unsigned k, input int unsigned len, input string tag);
        chk({"pop_count_", tag}, pop_cycles.size(), k);
        for (int i = 1; i < pop_cycles.size(); i++)
            chk($sformatf("pop_spacing_%s_%0d", tag, i), pop_cycles[i] - pop_cycles[i-1], len);
    endtask

    // FIFO model: pop on the edge where the DUT strobed rd_en
    always @(negedge clk) rd_seen = fif.fifo_rd_en;
    always @(posedge clk) begin
        cyc++;
        #2;
        if (rd_seen) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            else empty_pop++;
            pop_cycles.push_back(cyc);
            last_pop = cyc;
            rd_seen  = 1'b0;
        end
        refresh();
    end

    // Line monitor
    always @(negedge clk) begin
        if (rst) begin
            if (in_frame) n_abort++;
            in_frame = 1'b0;
            if (fif.fifo_rd_en !== 1'b0) rst_bad++;
            if (rst_prev && (o_tx !== 1'b1 || o_busy !== 1'b0 || o_frame_done !== 1'b0)) rst_bad++;
        end else begin
            if (!in_frame) begin
                if (o_tx === 1'b0) begin
                    if (exp_q.size() == 0) stray++;
                    else begin
                        cur      = exp_q.pop_front();
                        cur_len  = frame_len(cur);
                        fc       = 0;
                        wave_bad = 0;
                        busy_bad = 0;
                        done_bad = 0;
                        in_frame = 1'b1;
                        chk($sformatf("pop_to_start_%02h", cur.w), cyc - last_pop, 0);
                    end
                end else if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
                    idle_bad++;
                end
            end
            if (in_frame) begin
                if (o_tx !== exp_bit(cur, fc / CPB)) wave_bad++;
                if (o_busy !== 1'b1) busy_bad++;
                if (o_frame_done !== (fc == cur_len - 1)) done_bad++;
                fc++;
                if (fc == cur_len) begin
                    chk($sformatf("wave_%02h", cur.w), wave_bad, 0);
                    chk($sformatf("busy_%02h", cur.w), busy_bad, 0);
                    chk($sformatf("done_%02h", cur.w), done_bad, 0);
                    in_frame = 1'b0;
                end
            end
        end
        rst_prev = rst;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        exp_t e;

        // Reset with a pending word and transmit enabled
        tx_en = 1'b1;
        push(8'hA5);
        tick(6);
        chk("rst_outputs", rst_bad, 0);
        chk("rst_no_pop", pop_cycles.size(), 0);
        rst = 1'b0;
        wait_idle(200, "a5");
        check_spacing(1, 40, "a5");

        // Parity and stop-bit variants of 0x07
        pop_cycles.delete();
        pe = 1'b1; po = 1'b0; push(8'h07); wait_idle(200, "even");
        pe = 1'b1; po = 1'b1; push(8'h07); wait_idle(200, "odd");
        pe = 1'b1; po = 1'b0; ts = 1'b1; push(8'h07); wait_idle(200, "two_stop");
        pe = 1'b0; po = 1'b0; ts = 1'b0;

        // Back-to-back frames
        pop_cycles.delete();
        push(8'h55); push(8'hAA);
        wait_idle(300, "b2b");
        check_spacing(2, 40, "b2b");

        // Enabled with empty FIFO, then word pending with enable low
        pop_cycles.delete();
        tick(30);
        chk("empty_no_pop", pop_cycles.size(), 0);
        tx_en = 1'b0;
        push(8'h3C);
        tick(30);
        chk("disabled_no_pop", pop_cycles.size(), 0);
        tx_en = 1'b1;
        wait_idle(200, "enable");

        // Enable dropped mid-frame: frame completes, second word stays queued
        pop_cycles.delete();
        push(8'h81); push(8'h18);
        wait_pops(1, 50, "drop");
        tick(12);
        tx_en = 1'b0;
        k = 0;
        while (in_frame && k < 100) begin tick(1); k++; end
        tick(20);
        chk("drop_pops", pop_cycles.size(), 1);
        chk("drop_fifo_left", fifo_q.size(), 1);
        tx_en = 1'b1;
        wait_idle(200, "drop_resume");

        // Reset during data bit 3, then normal transmission
        pop_cycles.delete();
        push(8'hF0);
        wait_pops(1, 50, "rst_mid");
        tick(16);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_mid_outputs", rst_bad, 0);
        chk("rst_mid_abort", n_abort, 1);
        push(8'h9B);
        wait_idle(200, "after_rst");

        // Config changes mid-frame must not affect the frame in flight
        pop_cycles.delete();
        pe = 1'b1; po = 1'b1; ts = 1'b0;
        push(8'h6E);
        wait_pops(1, 50, "cfg");
        tick(5);
        pe = 1'b0; po = 1'b0; ts = 1'b1;
        wait_idle(200, "cfg");

        // Randomized batches
        for (int b = 0; b < 8; b++) begin
            pop_cycles.delete();
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            e.w = 8'h00; e.pe = pe; e.po = po; e.ts = ts;
            k = $urandom_range(1, 4);
            for (int i = 0; i < int'(k); i++) push(8'($urandom_range(0, 255)));
            wait_idle(800, $sformatf("rand%0d", b));
            check_spacing(k, frame_len(e), $sformatf("rand%0d", b));
        end

        chk("idle_line", idle_bad, 0);
        chk("stray_frames", stray, 0);
        chk("pop_while_empty", empty_pop, 0);
        chk("rst_total", rst_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
# uart_tx_fifo_reader

UART transmitter that drains the transmit FIFO and serialises each character onto the line. It is the read-side consumer of the TX FIFO: it pops one word when idle and the FIFO is non-empty, captures the word in the same cycle, then emits start, data (LSB first), optional parity and 1 or 2 stop bits at a fixed clocks-per-bit rate.

## Interface
- SIZE_DATA, 8, character width in bits (5..9)
- CLKS_PER_BIT, 16, clock cycles per UART bit (>= 2)
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous to i_clk, active-high
- i_fifo_empty  input  1  TX FIFO empty flag
- i_fifo_data  input  SIZE_DATA  FIFO read data, valid only in the cycle o_fifo_rd_en is high
- o_fifo_rd_en  output  1  FIFO pop strobe, one cycle per character
- i_tx_en  input  1  transmit enable; gates new pops only
- i_parity_en  input  1  append parity bit
- i_parity_odd  input  1  1 = odd parity, 0 = even
- i_two_stop  input  1  1 = two stop bits, 0 = one
- o_tx  output  1  serial line, idle high
- o_busy  output  1  high from start bit through last stop bit
- o_frame_done  output  1  one-cycle pulse in final cycle of last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: o_fifo_rd_en = i_tx_en & ~i_fifo_empty & (state==IDLE | final cycle of final STOP bit). Combinational, so FIFO data is captured on the same edge.
- On pop edge: shift register <= i_fifo_data; parity/stop config latched; bit counter cleared; state -> START. Config changes mid-frame have no effect.
- START: o_tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: SIZE_DATA bits, LSB first, each CLKS_PER_BIT cycles -> PARITY if latched parity enabled, else STOP.
- PARITY: bit = ^data XOR latched odd flag; CLKS_PER_BIT cycles -> STOP.
- STOP: o_tx=1 for 1 or 2 bit times. In final cycle: o_frame_done=1; if pop condition true go to START (no idle gap), else IDLE.
- i_tx_en low mid-frame: current frame completes; no further pops.
- i_fifo_empty ignored outside pop window.
- Reset mid-frame: next edge o_tx=1, state IDLE, counters cleared, no o_frame_done; popped character is discarded.
- Bit-time counter width $clog2(CLKS_PER_BIT); bit counter $clog2(SIZE_DATA+1); counters wrap only via explicit reload.

## Timing
- Reset values: o_tx=1, o_busy=0, o_frame_done=0, o_fifo_rd_en=0 (while i_rst high, regardless of inputs).
- o_tx, o_busy, o_frame_done registered; o_fifo_rd_en combinational from state and inputs.
- Pop at edge N -> o_tx low and o_busy high from cycle N+1.
- Frame length = CLKS_PER_BIT x (1 + SIZE_DATA + P + S), P in {0,1}, S in {1,2}.
- Back-to-back: successive pops exactly one frame length apart; start bit directly follows stop bit.
- o_busy falls the cycle after o_frame_done unless a new frame starts.

## Structure
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), parity/stop config struct, default SIZE_DATA and CLKS_PER_BIT constants; shared with the receiver.
- Sub-module uart_bit_timer: loadable down-counter producing a one-cycle bit_end pulse every CLKS_PER_BIT cycles while enabled; restarted on each pop.

## Test plan
(CLKS_PER_BIT=4, SIZE_DATA=8)
- Reset with FIFO non-empty and i_tx_en=1 -> o_tx=1, o_busy=0, o_fifo_rd_en=0 throughout reset.
- FIFO holds 0xA5, no parity, one stop -> single rd_en pulse; o_tx bit sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); o_frame_done in cycle 40 after pop.
- 0x07 with even parity -> parity bit 1; with odd -> 0; frame 44 cycles; two stop bits -> 48 cycles.
- FIFO holds 0x55, 0xAA -> rd_en pulses exactly 40 cycles apart, second start bit immediately after first stop bit, o_busy continuously high for 80 cycles.
- i_tx_en=1 with FIFO empty, or i_tx_en=0 with FIFO non-empty -> no rd_en, o_tx stays 1; i_tx_en dropped during DATA -> frame completes, no next pop.
- i_rst asserted during DATA bit 3 -> o_tx=1 and o_busy=0 on next edge, no o_frame_done; after release, next FIFO word transmits normally.
